// File: rtl/adam_spi_target_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adam_spi_target_pkg
// Description : Shared types and helpers for the adam_spi_target SPI target:
//               transfer state encoding and sample-edge selection.
// Revision    : 1.0 - initial release
// ============================================================================
package adam_spi_target_pkg;

    // Transfer state: IDLE while deselected, ACTIVE while ss is held low
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Data is sampled on the rising sck edge when CPOL matches CPHA,
    // otherwise on the falling edge; the other edge shifts.
    function automatic logic sample_on_rise(input int cpol, input int cpha);
        return (cpol == cpha);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adam_spi_target_sync.sv
`default_nettype none
// ============================================================================
// Module      : adam_spi_target_sync
// Description : Two-flop synchronizer bringing an SPI pin into the clk domain.
//               RESET_VAL sets the level both flops take during reset so the
//               pin appears idle as soon as reset is released.
// Revision    : 1.0 - initial release
// ============================================================================
module adam_spi_target_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops to settle metastability on the asynchronous pin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/adam_spi_target.sv
`default_nettype none
// ============================================================================
// Module      : adam_spi_target
// Description : SPI target (slave) with single-entry TX buffer and single
//               RX holding register. All SPI pins are synchronized into clk;
//               spi_sck must run at clk/8 or slower.
//               Optional macro ADAM_SPI_TARGET_STATUS_EN adds sticky
//               overrun/underrun flags and a status_clr input.
// Revision    : 1.0 - initial release
// ============================================================================
module adam_spi_target
    import adam_spi_target_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int MSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sck,
    input  logic                  spi_ss,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  busy
`ifdef ADAM_SPI_TARGET_STATUS_EN
    ,
    output logic                  overrun,
    output logic                  underrun,
    input  logic                  status_clr
`endif
);

    localparam int                c_CNT_W          = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT      = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic              c_SAMPLE_RISE    = sample_on_rise(CPOL, CPHA);
    localparam logic              c_DRIVE_ON_ENTRY = (CPHA == 0);

    // Synchronized pins and their one-cycle-delayed copies for edge detection
    logic w_sck_s, w_ss_s, w_mosi_s;
    logic r_sck_d, r_ss_d;

    logic w_sck_rise, w_sck_fall, w_ss_fall, w_ss_rise;
    logic w_sample_edge, w_shift_edge;

    state_t r_state, w_state_nxt;
    logic   w_enter, w_leave, w_run;
    logic   w_sample, w_shift, w_word_done, w_load, w_tx_hs;

    logic [DATA_WIDTH-1:0] r_tx_buf;
    logic                  r_tx_full;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic                  r_miso;
    logic [DATA_WIDTH-1:0] w_tx_word_in, w_drv_src, w_drv_rest;
    logic                  w_drv_bit;

    logic [DATA_WIDTH-2:0] r_rx_part;
    logic [DATA_WIDTH-2:0] w_rx_part_nxt;
    logic [DATA_WIDTH-1:0] w_rx_word;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;

    adam_spi_target_sync #(.RESET_VAL(CPOL != 0)) u_sync_sck (
        .clk (clk),
        .rst (rst),
        .d   (spi_sck),
        .q   (w_sck_s)
    );

    adam_spi_target_sync #(.RESET_VAL(1'b1)) u_sync_ss (
        .clk (clk),
        .rst (rst),
        .d   (spi_ss),
        .q   (w_ss_s)
    );

    adam_spi_target_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .d   (spi_mosi),
        .q   (w_mosi_s)
    );

    // Previous synchronized levels of sck and ss for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_d <= (CPOL != 0);
            r_ss_d  <= 1'b1;
        end else begin
            r_sck_d <= w_sck_s;
            r_ss_d  <= w_ss_s;
        end
    end

    assign w_sck_rise    = w_sck_s & ~r_sck_d;
    assign w_sck_fall    = ~w_sck_s & r_sck_d;
    assign w_ss_fall     = ~w_ss_s & r_ss_d;
    assign w_ss_rise     = w_ss_s & ~r_ss_d;
    assign w_sample_edge = c_SAMPLE_RISE ? w_sck_rise : w_sck_fall;
    assign w_shift_edge  = c_SAMPLE_RISE ? w_sck_fall : w_sck_rise;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic with entry/exit strobes
    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        w_leave     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ss_fall) begin
                    w_state_nxt = ACTIVE;
                    w_enter     = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_ss_rise) begin
                    w_state_nxt = IDLE;
                    w_leave     = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // sck edges count only while selected; a deselect wins over a coincident edge
    assign w_run       = (r_state == ACTIVE) && !w_ss_rise;
    assign w_sample    = w_run & w_sample_edge;
    assign w_shift     = w_run & w_shift_edge;
    assign w_word_done = w_sample && (r_bit_cnt == c_LAST_BIT);
    assign w_load      = w_enter | w_word_done;
    assign w_tx_hs     = tx_valid & ~r_tx_full;

    // An empty buffer at word start sends all-ones
    assign w_tx_word_in = r_tx_full ? r_tx_buf : {DATA_WIDTH{1'b1}};
    assign w_drv_src    = w_enter ? w_tx_word_in : r_tx_shift;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_drv_bit     = w_drv_src[DATA_WIDTH-1];
            assign w_drv_rest    = {w_drv_src[DATA_WIDTH-2:0], 1'b1};
            assign w_rx_word     = {r_rx_part, w_mosi_s};
            assign w_rx_part_nxt = w_rx_word[DATA_WIDTH-2:0];
        end else begin : g_lsb_first
            assign w_drv_bit     = w_drv_src[0];
            assign w_drv_rest    = {1'b1, w_drv_src[DATA_WIDTH-1:1]};
            assign w_rx_word     = {w_mosi_s, r_rx_part};
            assign w_rx_part_nxt = w_rx_word[DATA_WIDTH-1:1];
        end
    endgenerate

    // Single-entry TX buffer: accept when empty, empty when loaded into the shifter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_buf  <= '0;
            r_tx_full <= 1'b0;
        end else if (w_tx_hs) begin
            r_tx_buf  <= tx_data;
            r_tx_full <= 1'b1;
        end else if (w_load) begin
            r_tx_full <= 1'b0;
        end
    end

    // TX shifter: a freshly loaded word presents its first bit on the next shift
    // edge, except in CPHA=0 where the first bit must be out at selection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_shift <= '0;
            r_miso     <= 1'b0;
        end else if (w_leave) begin
            r_miso     <= 1'b0;
        end else if (w_enter && c_DRIVE_ON_ENTRY) begin
            r_miso     <= w_drv_bit;
            r_tx_shift <= w_drv_rest;
        end else if (w_load) begin
            r_tx_shift <= w_tx_word_in;
        end else if (w_shift) begin
            r_miso     <= w_drv_bit;
            r_tx_shift <= w_drv_rest;
        end
    end

    // RX shifter and bit counter; a deselect discards any partial word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_part <= '0;
            r_bit_cnt <= '0;
        end else if (w_leave) begin
            r_rx_part <= '0;
            r_bit_cnt <= '0;
        end else if (w_sample) begin
            r_rx_part <= w_rx_part_nxt;
            r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + c_CNT_W'(1);
        end
    end

    // RX holding register: new word only if the slot is free or being read now
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else if (w_word_done && (!r_rx_valid || rx_ready)) begin
            r_rx_data  <= w_rx_word;
            r_rx_valid <= 1'b1;
        end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
        end
    end

`ifdef ADAM_SPI_TARGET_STATUS_EN
    logic w_overrun_set, w_underrun_set;
    logic r_overrun, r_underrun;

    assign w_overrun_set  = w_word_done && r_rx_valid && !rx_ready;
    assign w_underrun_set = w_load && !r_tx_full;

    // Sticky status flags; a new event beats a clear in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (status_clr) begin
                r_overrun <= 1'b0;
            end
            if (w_underrun_set) begin
                r_underrun <= 1'b1;
            end else if (status_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign overrun  = r_overrun;
    assign underrun = r_underrun;
`endif

    assign spi_miso_oe = (r_state == ACTIVE);
    assign spi_miso    = r_miso & spi_miso_oe;
    assign busy        = (r_state == ACTIVE);
    assign tx_ready    = ~r_tx_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_adam_spi_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_adam_spi_target
// Description : Self-checking bench for adam_spi_target. One mode-0 and one
//               mode-3 instance share sck/mosi; each has its own ss. Expected
//               RX words are queued by the stimulus and popped by per-instance
//               monitors on each rx handshake; MISO words are queued likewise
//               and compared by the bus master as each word completes.
//               Status flags are checked when ADAM_SPI_TARGET_STATUS_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adam_spi_target;

    localparam int DW   = 8;
    localparam int HALF = 4;   // clk cycles per sck half period (sck = clk/8)

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          sck, mosi, ss0, ss3;
    logic [DW-1:0] tx_data;
    logic          tx_valid0, tx_valid3, rx_ready0, rx_ready3;
    logic          miso0, oe0, tx_ready0, rx_valid0, busy0;
    logic          miso3, oe3, tx_ready3, rx_valid3, busy3;
    logic [DW-1:0] rx_data0, rx_data3;
`ifdef ADAM_SPI_TARGET_STATUS_EN
    logic          overrun0, underrun0, overrun3, underrun3, status_clr;
`endif

    int n_run  = 0;
    int n_fail = 0;

    logic [DW-1:0] exp_rx0[$];
    logic [DW-1:0] exp_rx3[$];
    logic [DW-1:0] exp_miso0[$];
    logic [DW-1:0] exp_miso3[$];

    adam_spi_target #(.DATA_WIDTH(DW), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) dut0 (
        .clk(clk), .rst(rst), .spi_sck(sck), .spi_ss(ss0), .spi_mosi(mosi),
        .spi_miso(miso0), .spi_miso_oe(oe0),
        .tx_data(tx_data), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
        .busy(busy0)
`ifdef ADAM_SPI_TARGET_STATUS_EN
        , .overrun(overrun0), .underrun(underrun0), .status_clr(status_clr)
`endif
    );

    adam_spi_target #(.DATA_WIDTH(DW), .CPOL(1), .CPHA(1), .MSB_FIRST(1)) dut3 (
        .clk(clk), .rst(rst), .spi_sck(sck), .spi_ss(ss3), .spi_mosi(mosi),
        .spi_miso(miso3), .spi_miso_oe(oe3),
        .tx_data(tx_data), .tx_valid(tx_valid3), .tx_ready(tx_ready3),
        .rx_data(rx_data3), .rx_valid(rx_valid3), .rx_ready(rx_ready3),
        .busy(busy3)
`ifdef ADAM_SPI_TARGET_STATUS_EN
        , .overrun(overrun3), .underrun(underrun3), .status_clr(status_clr)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // RX monitors: every handshake must match the oldest expected word
    always @(negedge clk) begin
        if (!rst && rx_valid0 && rx_ready0) begin
            if (exp_rx0.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL rx0_unexpected: got 0x%0h, expected no word", rx_data0);
            end else begin
                check("rx0_data", rx_data0, exp_rx0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rx_valid3 && rx_ready3) begin
            if (exp_rx3.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL rx3_unexpected: got 0x%0h, expected no word", rx_data3);
            end else begin
                check("rx3_data", rx_data3, exp_rx3.pop_front());
            end
        end
    end

    function automatic logic [DW-1:0] pop_miso(input int which);
        if (which == 3) return (exp_miso3.size() != 0) ? exp_miso3.pop_front() : 'x;
        return (exp_miso0.size() != 0) ? exp_miso0.pop_front() : 'x;
    endfunction

    task automatic set_ss(input int which, input logic v);
        if (which == 3) ss3 = v; else ss0 = v;
    endtask

    task automatic set_rdy0(input logic v);
        @(posedge clk);
        #1 rx_ready0 = v;
    endtask

    task automatic pulse_clr;
`ifdef ADAM_SPI_TARGET_STATUS_EN
        @(negedge clk) status_clr = 1'b1;
        @(negedge clk) status_clr = 1'b0;
`else
        @(negedge clk);
`endif
    endtask

    task automatic tx_push(input int which, input logic [DW-1:0] d);
        bit done = 1'b0;
        @(negedge clk);
        tx_data = d;
        if (which == 3) tx_valid3 = 1'b1; else tx_valid0 = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            if ((which == 3) ? tx_ready3 : tx_ready0) done = 1'b1;
            @(negedge clk);
        end
        if (which == 3) tx_valid3 = 1'b0; else tx_valid0 = 1'b0;
        check("tx_push_accept", {31'd0, done}, 32'd1);
    endtask

    // One word (or the first nbits of it) as bus master, MSB first
    task automatic spi_word(input int which, input logic [DW-1:0] tx, input int nbits,
                            output logic [DW-1:0] got);
        logic cpol = (which == 3);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            if (which == 3) begin
                sck  = ~cpol;
                mosi = tx[DW-1-i];
                repeat (HALF) @(negedge clk);
                sck  = cpol;
                got  = {got[DW-2:0], miso3};
                repeat (HALF) @(negedge clk);
            end else begin
                mosi = tx[DW-1-i];
                repeat (HALF) @(negedge clk);
                sck  = ~cpol;
                got  = {got[DW-2:0], miso0};
                repeat (HALF) @(negedge clk);
                sck  = cpol;
            end
        end
    endtask

    task automatic spi_xfer(input int which, input int n, input logic [DW-1:0] w0,
                            input logic [DW-1:0] w1);
        logic [DW-1:0] got;
        @(negedge clk);
        sck = (which == 3);
        set_ss(which, 1'b0);
        repeat (2*HALF) @(negedge clk);
        check("busy_selected", (which == 3) ? busy3 : busy0, 1);
        check("oe_selected", (which == 3) ? oe3 : oe0, 1);
        for (int k = 0; k < n; k++) begin
            spi_word(which, (k == 0) ? w0 : w1, DW, got);
            check("miso_word", got, pop_miso(which));
        end
        repeat (HALF) @(negedge clk);
        set_ss(which, 1'b1);
        repeat (2*HALF) @(negedge clk);
        check("busy_deselected", (which == 3) ? busy3 : busy0, 0);
    endtask

    task automatic wait_drain;
        for (int i = 0; i < 300 && (exp_rx0.size() + exp_rx3.size()) != 0; i++)
            @(negedge clk);
        check("rx_queue_drained", exp_rx0.size() + exp_rx3.size(), 0);
    endtask

    task automatic check_reset0(input string tag);
        check({tag, "_tx_ready"}, tx_ready0, 1);
        check({tag, "_rx_valid"}, rx_valid0, 0);
        check({tag, "_rx_data"}, rx_data0, 0);
        check({tag, "_miso"}, miso0, 0);
        check({tag, "_oe"}, oe0, 0);
        check({tag, "_busy"}, busy0, 0);
`ifdef ADAM_SPI_TARGET_STATUS_EN
        check({tag, "_flags"}, {overrun0, underrun0}, 0);
`endif
    endtask

    initial begin
        logic [DW-1:0] got;
        rst = 1'b1; sck = 1'b0; mosi = 1'b0; ss0 = 1'b1; ss3 = 1'b1;
        tx_data = '0; tx_valid0 = 1'b0; tx_valid3 = 1'b0;
        rx_ready0 = 1'b1; rx_ready3 = 1'b1;
`ifdef ADAM_SPI_TARGET_STATUS_EN
        status_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_reset0("por0");
        check("por3_state", {tx_ready3, rx_valid3, miso3, oe3, busy3}, 5'b10000);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Mode 0 single word; rx_valid holds until rx_ready
        set_rdy0(1'b0);
        tx_push(0, 8'hA5);
        exp_miso0.push_back(8'hA5);
        exp_rx0.push_back(8'h3C);
        spi_xfer(0, 1, 8'h3C, 8'h00);
        repeat (5) @(negedge clk);
        check("rx_valid_held", rx_valid0, 1);
        set_rdy0(1'b1);
        wait_drain();
        repeat (2) @(negedge clk);
        check("rx_valid_dropped", rx_valid0, 0);

        // Mode 3, two back-to-back words, second TX word pushed mid-transfer
        @(negedge clk) sck = 1'b1;
        repeat (4) @(negedge clk);
        tx_push(3, 8'h12);
        exp_miso3.push_back(8'h12);
        exp_miso3.push_back(8'h34);
        exp_rx3.push_back(8'h55);
        exp_rx3.push_back(8'hAA);
        fork
            tx_push(3, 8'h34);
            spi_xfer(3, 2, 8'h55, 8'hAA);
        join
        wait_drain();
        @(negedge clk) sck = 1'b0;
        repeat (4) @(negedge clk);

        // Empty TX buffer: all-ones on MISO, underrun flagged
        pulse_clr();
        exp_miso0.push_back(8'hFF);
        exp_rx0.push_back(8'h01);
        spi_xfer(0, 1, 8'h01, 8'h00);
        wait_drain();
        check("tx_ready_empty", tx_ready0, 1);
`ifdef ADAM_SPI_TARGET_STATUS_EN
        check("underrun_set", underrun0, 1);
`endif

        // Overrun: second word dropped while first unread
        set_rdy0(1'b0);
        pulse_clr();
        exp_miso0.push_back(8'hFF);
        exp_miso0.push_back(8'hFF);
        exp_rx0.push_back(8'h11);
        spi_xfer(0, 2, 8'h11, 8'h22);
        repeat (4) @(negedge clk);
        check("ovr_rx_valid", rx_valid0, 1);
        check("ovr_rx_data_kept", rx_data0, 8'h11);
`ifdef ADAM_SPI_TARGET_STATUS_EN
        check("overrun_set", overrun0, 1);
        pulse_clr();
        check("status_cleared", {overrun0, underrun0}, 0);
`endif
        set_rdy0(1'b1);
        wait_drain();
        repeat (2) @(negedge clk);
        check("ovr_rx_valid_dropped", rx_valid0, 0);

        // Abort after 4 bits; buffered-but-unloaded TX word survives
        tx_push(0, 8'h81);
        @(negedge clk) ss0 = 1'b0;
        repeat (2*HALF) @(negedge clk);
        tx_push(0, 8'h66);
        spi_word(0, 8'hF0, 4, got);
        check("abort_partial_miso", got, 8'h08);
        ss0 = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_oe_low", {oe0, miso0, busy0}, 3'b000);
        check("abort_tx_kept", tx_ready0, 0);
        repeat (2*HALF) @(negedge clk);
        exp_miso0.push_back(8'h66);
        exp_rx0.push_back(8'h0F);
        spi_xfer(0, 1, 8'h0F, 8'h00);
        wait_drain();

        // Asynchronous reset mid-transfer, then a clean transfer
        tx_push(0, 8'h5A);
        @(negedge clk) ss0 = 1'b0;
        repeat (2*HALF) @(negedge clk);
        spi_word(0, 8'hC3, 3, got);
        check("pre_reset_partial_miso", got, 8'h02);
        mosi = 1'b0;
        repeat (2) @(negedge clk);
        sck = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset0("async_rst");
        ss0 = 1'b1; sck = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tx_push(0, 8'h3C);
        exp_miso0.push_back(8'h3C);
        exp_rx0.push_back(8'hC3);
        spi_xfer(0, 1, 8'hC3, 8'h00);
        wait_drain();

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adam_spi_target.md
ADAM_SPI_TARGET -- requirements
Module: adam_spi_target

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per SPI word (4..32).
REQ-002 SHALL have parameter CPOL, default 0, idle level of spi_sck.
REQ-003 SHALL have parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 SHALL have parameter MSB_FIRST, default 1; 1 = MSB shifted first.
REQ-005 SHALL have ports: clk in 1 system clock; rst in 1 asynchronous active-high reset.
REQ-006 SHALL have ports: spi_sck in 1; spi_ss in 1 (active low); spi_mosi in 1; spi_miso out 1; spi_miso_oe out 1 (tristate enable).
REQ-007 SHALL have ports: tx_data in DATA_WIDTH; tx_valid in 1; tx_ready out 1 (next word to send).
REQ-008 SHALL have ports: rx_data out DATA_WIDTH; rx_valid out 1; rx_ready in 1 (received word).
REQ-009 SHALL have port busy out 1, high while a transfer is selected.

Function
REQ-010 SHALL pass spi_sck, spi_ss and spi_mosi through 2-flop synchronizers; all logic runs on clk; spi_sck frequency SHALL be at most clk/8.
REQ-011 SHALL implement states IDLE and ACTIVE: IDLE->ACTIVE on synchronized ss falling; ACTIVE->IDLE on synchronized ss rising.
REQ-012 SHALL define sample edge as rising when CPOL==CPHA, else falling; the opposite edge is the shift edge.
REQ-013 SHALL hold a single-entry TX buffer; tx_ready high when empty; handshake on tx_valid && tx_ready.
REQ-014 SHALL load the shift register from the TX buffer at word start (entering ACTIVE, or after the last sample of a word), emptying it; if empty, load all-ones and record underrun.
REQ-015 SHALL, for CPHA=0, drive the first bit on entering ACTIVE and subsequent bits on shift edges; for CPHA=1, drive each bit on the shift edge preceding its sample edge.
REQ-016 SHALL drive spi_miso_oe high only in ACTIVE; spi_miso SHALL be 0 when spi_miso_oe is low.
REQ-017 SHALL count sample edges modulo DATA_WIDTH; on count DATA_WIDTH-1 it SHALL present the word on rx_data with rx_valid high exactly 1 clk after the synchronized sample edge is detected.
REQ-018 SHALL hold rx_data/rx_valid until rx_valid && rx_ready; rx_valid SHALL then drop the next cycle unless a new word completes that same cycle.
REQ-019 SHALL, when a word completes while rx_valid high and rx_ready low, drop the new word, keep the old one, and record overrun.
REQ-020 SHALL treat completion coinciding with rx_ready handshake as accepted (no overrun, new word valid next cycle).
REQ-021 SHALL, on ss rising mid-word, discard the partial RX word, reset the bit counter, keep an unloaded TX buffer entry, and drop spi_miso_oe within 3 clk.
REQ-022 SHALL ignore sck edges while in IDLE.

Reset
REQ-023 SHALL on rst: state IDLE, TX buffer empty, tx_ready 1, rx_valid 0, rx_data 0, spi_miso 0, spi_miso_oe 0, busy 0, bit counter 0, synchronizers to idle levels (sck=CPOL, ss=1, mosi=0), status flags 0.

Configuration
REQ-024 SHALL, with ADAM_SPI_TARGET_STATUS_EN defined, add outputs overrun (1), underrun (1) sticky flags and input status_clr (1) clearing both; set wins over clear in the same cycle.
REQ-025 SHALL, without ADAM_SPI_TARGET_STATUS_EN, omit those ports and flag logic; data behaviour identical.

Structure
REQ-026 SHALL place the state enum (IDLE, ACTIVE) and sample-edge selection function in package adam_spi_target_pkg.
REQ-027 SHALL use sub-module adam_spi_target_sync (2-flop synchronizer with reset value parameter), instanced three times.

Verification
REQ-028 Mode 0, tx 0xA5 preloaded, master sends 0x3C at clk/8 -> master reads 0xA5; rx_data 0x3C with rx_valid one pulse until rx_ready.
REQ-029 Mode 3, two back-to-back words, tx 0x12 then 0x34, master sends 0x55,0xAA -> MISO 0x12,0x34; rx 0x55 then 0xAA.
REQ-030 Empty TX buffer, master sends 0x01 -> MISO 0xFF; underrun=1 (STATUS_EN); rx 0x01.
REQ-031 rx_ready held 0, two words 0x11,0x22 -> rx_data stays 0x11; overrun=1; status_clr clears it.
REQ-032 ss rises after 4 bits of 0xF0 -> no rx_valid, spi_miso_oe 0 within 3 clk; next full transfer 0x0F received correctly.
REQ-033 rst asserted mid-transfer -> all outputs at reset values immediately (asynchronous), next transfer correct.
